// File: rtl/ahb_xfer_sequencer.sv
// ahb_xfer_sequencer
//   Command-driven front end for ahb_manager. Expands one {addr,len,size,wrap,dir} command
//   into len beats on the manager user interface, inserting BUSY beats when write data or
//   read-buffer credit is missing, and buffers returning read data in a credit-managed FIFO.
//
// Ports
//   i_hclk, i_hreset          clock, asynchronous active-high reset
//   i_cmd_*, o_cmd_ready      command channel (valid/ready)
//   i_wdata*, o_wdata_ready   write-data stream in
//   o_rdata*, i_rdata_ready   read-data stream out (with beat address)
//   o_busy, o_done, o_error   status: not idle, 1-cycle completion pulse, sticky error
//   o_idle..o_wr_data         registered user-interface word to ahb_manager
//   i_stall, i_err, i_rd_*    feedback from ahb_manager
module ahb_xfer_sequencer #(
  parameter int unsigned DATA_WDT      = 32,
  parameter int unsigned RD_FIFO_DEPTH = 8
) (
  input  logic                i_hclk,
  input  logic                i_hreset,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic                i_cmd_wr,
  input  logic [31:0]         i_cmd_addr,
  input  logic [15:0]         i_cmd_len,
  input  logic [2:0]          i_cmd_size,
  input  logic                i_cmd_wrap,
  input  logic                i_wdata_valid,
  output logic                o_wdata_ready,
  input  logic [DATA_WDT-1:0] i_wdata,
  output logic                o_rdata_valid,
  input  logic                i_rdata_ready,
  output logic [DATA_WDT-1:0] o_rdata,
  output logic [31:0]         o_rdata_addr,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_error,
  output logic                o_idle,
  output logic                o_wr,
  output logic                o_rd,
  output logic                o_first_xfer,
  output logic [31:0]         o_addr,
  output logic [2:0]          o_size,
  output logic                o_wrap,
  output logic [15:0]         o_min_len,
  output logic [DATA_WDT-1:0] o_wr_data,
  input  logic                i_stall,
  input  logic                i_err,
  input  logic [DATA_WDT-1:0] i_rd_data,
  input  logic [31:0]         i_rd_data_addr,
  input  logic                i_rd_data_dav
);

  localparam int unsigned CntW = $clog2(RD_FIFO_DEPTH + 1);
  localparam int unsigned PtrW = $clog2(RD_FIFO_DEPTH);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StXfer  = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StErr   = 2'd3;

  logic [1:0]          state_q, state_d;
  logic                cmd_wr_q;
  logic [31:0]         cmd_addr_q;
  logic [15:0]         cmd_len_q;
  logic [2:0]          cmd_size_q;
  logic                cmd_wrap_q;
  logic [15:0]         remaining_q, remaining_d;
  logic                first_q, first_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [CntW-1:0]     outstanding_q, outstanding_d;
  logic [CntW-1:0]     occ_q, occ_d;
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [DATA_WDT+31:0] fifo_mem [RD_FIFO_DEPTH];

  logic                ui_idle_q, ui_idle_d;
  logic                ui_wr_q, ui_wr_d;
  logic                ui_rd_q, ui_rd_d;
  logic                ui_first_q, ui_first_d;
  logic [31:0]         ui_addr_q, ui_addr_d;
  logic [2:0]          ui_size_q, ui_size_d;
  logic                ui_wrap_q, ui_wrap_d;
  logic [15:0]         ui_min_len_q, ui_min_len_d;
  logic [DATA_WDT-1:0] ui_wr_data_q, ui_wr_data_d;

  logic            load, cmd_fire, wpop, rpop, push, full, overflow, err_now;
  logic            credit_ok, beat_ok, real_beat, last_beat, rd_real;
  logic [CntW:0]   credit_used;

  // The UI word only advances on edges the manager is not stalling.
  assign load          = ~i_stall;
  assign o_cmd_ready   = (state_q == StIdle) & ~i_stall;
  assign cmd_fire      = i_cmd_valid & o_cmd_ready;
  assign o_wdata_ready = (state_q == StXfer) & cmd_wr_q & ~i_stall & (remaining_q != '0);
  assign wpop          = o_wdata_ready & i_wdata_valid;

  assign o_rdata_valid = (occ_q != '0);
  assign rpop          = o_rdata_valid & i_rdata_ready;
  assign full          = (occ_q == CntW'(RD_FIFO_DEPTH));
  // A simultaneous pop frees the slot, so a push into a full FIFO is only lost without one.
  assign overflow      = i_rd_data_dav & full & ~rpop;
  assign push          = i_rd_data_dav & ~overflow;
  assign err_now       = i_err | overflow;

  // Reads in flight plus buffered data must fit the FIFO before another read beat issues.
  assign credit_used = {1'b0, occ_q} + {1'b0, outstanding_q};
  assign credit_ok   = credit_used < (CntW + 1)'(RD_FIFO_DEPTH);
  assign beat_ok     = cmd_wr_q ? i_wdata_valid : credit_ok;
  assign real_beat   = (state_q == StXfer) & load & beat_ok & ~err_now & (remaining_q != '0);
  assign last_beat   = real_beat & (remaining_q == 16'd1);
  assign rd_real     = real_beat & ~cmd_wr_q;

  assign {o_rdata, o_rdata_addr} = fifo_mem[rd_ptr_q];

  assign o_busy       = (state_q != StIdle);
  assign o_done       = done_q;
  assign o_error      = error_q;
  assign o_idle       = ui_idle_q;
  assign o_wr         = ui_wr_q;
  assign o_rd         = ui_rd_q;
  assign o_first_xfer = ui_first_q;
  assign o_addr       = ui_addr_q;
  assign o_size       = ui_size_q;
  assign o_wrap       = ui_wrap_q;
  assign o_min_len    = ui_min_len_q;
  assign o_wr_data    = ui_wr_data_q;

  always_comb begin
    outstanding_d = outstanding_q;
    if (rd_real && !i_rd_data_dav) begin
      outstanding_d = outstanding_q + CntW'(1);
    end else if (!rd_real && i_rd_data_dav && (outstanding_q != '0)) begin
      outstanding_d = outstanding_q - CntW'(1);
    end
    occ_d = occ_q + CntW'(push) - CntW'(rpop);
  end

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    first_d      = first_q;
    done_d       = 1'b0;
    error_d      = error_q | err_now;
    ui_idle_d    = ui_idle_q;
    ui_wr_d      = ui_wr_q;
    ui_rd_d      = ui_rd_q;
    ui_first_d   = ui_first_q;
    ui_addr_d    = ui_addr_q;
    ui_size_d    = ui_size_q;
    ui_wrap_d    = ui_wrap_q;
    ui_min_len_d = ui_min_len_q;
    ui_wr_data_d = ui_wr_data_q;

    if (wpop) begin
      ui_wr_data_d = i_wdata;
    end

    unique case (state_q)
      StIdle: begin
        if (cmd_fire) begin
          remaining_d = i_cmd_len;
          first_d     = 1'b1;
          if (i_cmd_len != 16'd0) begin
            state_d = StXfer;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StXfer: begin
        if (real_beat) begin
          remaining_d = remaining_q - 16'd1;
          first_d     = 1'b0;
          if (last_beat) begin
            if (cmd_wr_q) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              state_d = StDrain;
            end
          end
        end
      end
      StDrain: begin
        if (outstanding_q == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase

    if (load) begin
      if (real_beat) begin
        ui_idle_d  = 1'b0;
        ui_wr_d    = cmd_wr_q;
        ui_rd_d    = ~cmd_wr_q;
        ui_first_d = first_q;
        ui_size_d  = cmd_size_q;
        ui_wrap_d  = cmd_wrap_q;
        if (first_q) begin
          ui_addr_d    = cmd_addr_q;
          ui_min_len_d = cmd_len_q;
        end
      end else if ((state_q == StXfer) && !err_now) begin
        // BUSY beat keeps the burst open while data or credit is missing.
        ui_idle_d  = 1'b0;
        ui_wr_d    = 1'b0;
        ui_rd_d    = 1'b0;
        ui_first_d = 1'b0;
      end else begin
        ui_idle_d  = 1'b1;
        ui_wr_d    = 1'b0;
        ui_rd_d    = 1'b0;
        ui_first_d = 1'b1;
      end
    end

    if (err_now) begin
      state_d = StErr;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      state_q       <= StIdle;
      cmd_wr_q      <= 1'b0;
      cmd_addr_q    <= '0;
      cmd_len_q     <= '0;
      cmd_size_q    <= '0;
      cmd_wrap_q    <= 1'b0;
      remaining_q   <= '0;
      first_q       <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      outstanding_q <= '0;
      occ_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      ui_idle_q     <= 1'b1;
      ui_wr_q       <= 1'b0;
      ui_rd_q       <= 1'b0;
      ui_first_q    <= 1'b1;
      ui_addr_q     <= '0;
      ui_size_q     <= '0;
      ui_wrap_q     <= 1'b0;
      ui_min_len_q  <= '0;
      ui_wr_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      if (cmd_fire) begin
        cmd_wr_q   <= i_cmd_wr;
        cmd_addr_q <= i_cmd_addr;
        cmd_len_q  <= i_cmd_len;
        cmd_size_q <= i_cmd_size;
        cmd_wrap_q <= i_cmd_wrap;
      end
      remaining_q   <= remaining_d;
      first_q       <= first_d;
      done_q        <= done_d;
      error_q       <= error_d;
      outstanding_q <= outstanding_d;
      occ_q         <= occ_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (rpop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      ui_idle_q     <= ui_idle_d;
      ui_wr_q       <= ui_wr_d;
      ui_rd_q       <= ui_rd_d;
      ui_first_q    <= ui_first_d;
      ui_addr_q     <= ui_addr_d;
      ui_size_q     <= ui_size_d;
      ui_wrap_q     <= ui_wrap_d;
      ui_min_len_q  <= ui_min_len_d;
      ui_wr_data_q  <= ui_wr_data_d;
    end
  end

  always_ff @(posedge i_hclk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {i_rd_data, i_rd_data_addr};
    end
  end

endmodule
